// File: rtl/serial_to_parallel.sv
// -----------------------------------------------------------------------------
// serial_to_parallel
//
// Deserializer in front of the circular-convolution datapath. Collects WIDTH
// consecutive XLEN-bit serial words into one WIDTH-lane parallel frame and
// announces each completed frame with a single-cycle parallel_valid pulse.
// Lane 0 of the frame is the first word received.
//
// A word flagged with serial_first while a frame is partially collected
// restarts collection at lane 0; the discarded partial frame is reported with
// a single-cycle frame_error pulse.
//
// Optional feature (macro SERIAL_TO_PARALLEL_TIMEOUT_EN):
//   When defined, a partial frame that sees TIMEOUT consecutive idle cycles is
//   dropped and frame_error pulses. When undefined, a partial frame waits
//   indefinitely and TIMEOUT has no effect.
//
// Parameters:
//   XLEN    - bits per serial word / frame lane
//   WIDTH   - words per frame (>= 2)
//   TIMEOUT - idle-cycle limit for a partial frame (>= 1), optional feature only
//
// Ports:
//   clk            - clock, all logic on the rising edge
//   rst            - synchronous active-high reset
//   serial_valid   - qualifies serial_data / serial_first
//   serial_first   - word is lane 0 of a new frame (ignored without serial_valid)
//   serial_data    - serial word
//   parallel_valid - one-cycle pulse, parallel_data holds a new complete frame
//   parallel_data  - completed frame, [lane][bit], lane 0 = first word
//   frame_error    - one-cycle pulse, a partial frame was discarded
// -----------------------------------------------------------------------------
module serial_to_parallel #(
    parameter int XLEN    = 8,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        serial_valid,
    input  logic                        serial_first,
    input  logic [XLEN-1:0]             serial_data,
    output logic                        parallel_valid,
    output logic [WIDTH-1:0][XLEN-1:0]  parallel_data,
    output logic                        frame_error
);

    localparam int PTR_W = $clog2(WIDTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WIDTH - 1);

    // The collection state is fully described by the lane pointer: an empty
    // pointer means no partial frame is held.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    logic [PTR_W-1:0]              r_ptr;
    logic [WIDTH-2:0][XLEN-1:0]    r_buf;   // lanes 0..WIDTH-2; last lane comes straight from the input

    state_t                        w_state;
    logic                          w_resync;
    logic                          w_complete;
    logic                          w_append;
    logic                          w_timeout;
    logic                          w_buf_we;
    logic [PTR_W-1:0]              w_buf_idx;

    assign w_state = (r_ptr == '0) ? ST_IDLE : ST_FILL;

    // Word classification. These are mutually exclusive; resync has priority
    // over completion so that a serial_first on the last lane restarts the
    // frame instead of finishing it.
    assign w_resync   = serial_valid && serial_first && (w_state == ST_FILL);
    assign w_complete = serial_valid && !w_resync && (r_ptr == LAST_PTR);
    assign w_append   = serial_valid && !w_resync && !w_complete;

    // A resync word always lands in lane 0 regardless of the current pointer.
    assign w_buf_we  = w_append || w_resync;
    assign w_buf_idx = w_resync ? '0 : r_ptr;

`ifdef SERIAL_TO_PARALLEL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_idle_cnt;

    // Expiry fires on the idle cycle that would bring the count to TIMEOUT,
    // so the counter never actually holds TIMEOUT. An accepted word in that
    // same cycle keeps the frame alive because serial_valid masks expiry.
    assign w_timeout = !serial_valid && (w_state == ST_FILL) &&
                       (r_idle_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (serial_valid || (w_state == ST_IDLE) || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
        end
    end
`else
    // No idle limit: a partial frame is held until more words arrive.
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT);
    assign w_timeout        = 1'b0;
`endif

    // NOTE: the shadow buffer has no reset; every lane is written before it is
    // ever presented on parallel_data, so resetting it would only cost logic.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (w_buf_we && (w_buf_idx == PTR_W'(i))) begin
                r_buf[i] <= serial_data;
            end
        end
    end

    // Pointer, output frame register and status pulses.
    // NOTE: state registers use non-blocking assignments so every branch sees
    // the pre-edge values, and the default pulse clears below are overridden
    // cleanly by the later branch that sets them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr          <= '0;
            parallel_valid <= 1'b0;
            frame_error    <= 1'b0;
            parallel_data  <= '0;
        end else begin
            parallel_valid <= 1'b0;
            frame_error    <= 1'b0;

            if (w_resync) begin
                // Partial frame dropped; this word is lane 0 of the new one.
                // parallel_data keeps the last completed frame.
                r_ptr       <= PTR_W'(1);
                frame_error <= 1'b1;
            end else if (w_complete) begin
                parallel_data  <= {serial_data, r_buf};
                parallel_valid <= 1'b1;
                r_ptr          <= '0;
            end else if (w_append) begin
                // In IDLE this also covers a word without serial_first: it is
                // simply taken as lane 0.
                r_ptr <= r_ptr + PTR_W'(1);
            end else if (w_timeout) begin
                r_ptr       <= '0;
                frame_error <= 1'b1;
            end
        end
    end

endmodule
